// File: rtl/popcount_cxu_pipe_if.sv
// Request/response bundle for the popcount CXU; the requester takes the master side.
// Zero-width ID fields are carried as one unused bit so the bundle always elaborates.
interface popcount_cxu_pipe_if #(
  parameter int CXU_CXU_ID_W  = 0,
  parameter int CXU_FUNC_ID_W = 0,
  parameter int CXU_DATA_W    = 32,
  parameter int CXU_STATUS_W  = 3
);
  localparam int CXU_W  = (CXU_CXU_ID_W  > 0) ? CXU_CXU_ID_W  : 1;
  localparam int FUNC_W = (CXU_FUNC_ID_W > 0) ? CXU_FUNC_ID_W : 1;

  logic                    req_valid;
  logic [CXU_W-1:0]        req_cxu;
  logic [FUNC_W-1:0]       req_func;
  logic [CXU_DATA_W-1:0]   req_data0;
  logic [CXU_DATA_W-1:0]   req_data1;
  logic                    resp_valid;
  logic [CXU_STATUS_W-1:0] resp_status;
  logic [CXU_DATA_W-1:0]   resp_data;

  modport master (
    output req_valid, req_cxu, req_func, req_data0, req_data1,
    input  resp_valid, resp_status, resp_data
  );

  modport slave (
    input  req_valid, req_cxu, req_func, req_data0, req_data1,
    output resp_valid, resp_status, resp_data
  );
endinterface

// File: rtl/popcount_cxu_pipe.sv
// Population count of req_data0 through a generated adder tree; 1-cycle latency,
// one request per cycle, no backpressure (every response must be taken).
module popcount_cxu_pipe #(
  parameter int CXU_LI_VERSION = 0,
  parameter int CXU_N_CXUS     = 1,
  parameter int CXU_CXU_ID_W   = 0,
  parameter int CXU_FUNC_ID_W  = 0,
  parameter int CXU_DATA_W     = 32,
  parameter int CXU_STATUS_W   = 3
) (
  input  logic                clk,
  input  logic                rst_n,
  popcount_cxu_pipe_if.slave  cxu
);
  localparam logic [CXU_STATUS_W-1:0] CXU_STATUS_SUCCESS = '0;
  localparam int LEVELS  = $clog2(CXU_DATA_W);
  localparam int COUNT_W = LEVELS + 1;

  if (CXU_DATA_W != 32 && CXU_DATA_W != 64) begin : g_bad_width
    $error("popcount_cxu_pipe: CXU_DATA_W must be 32 or 64");
  end

  // Level k holds DATA_W>>(k+1) partial sums, each k+2 bits wide.
  genvar g_l, g_n;
  for (g_l = 0; g_l < LEVELS; g_l++) begin : g_lvl
    localparam int N = CXU_DATA_W >> (g_l + 1);
    localparam int W = g_l + 2;
    logic [N-1:0][W-1:0] w_sum;
    for (g_n = 0; g_n < N; g_n++) begin : g_node
      if (g_l == 0) begin : g_leaf
        assign w_sum[g_n] = {1'b0, cxu.req_data0[2*g_n]} + {1'b0, cxu.req_data0[2*g_n+1]};
      end else begin : g_add
        assign w_sum[g_n] = {1'b0, g_lvl[g_l-1].w_sum[2*g_n]}
                          + {1'b0, g_lvl[g_l-1].w_sum[2*g_n+1]};
      end
    end
  end

  logic [COUNT_W-1:0]    w_count;
  logic [CXU_DATA_W-1:0] w_result;
  assign w_count  = g_lvl[LEVELS-1].w_sum[0];
  assign w_result = {{(CXU_DATA_W-COUNT_W){1'b0}}, w_count};

  logic w_unused;
  assign w_unused = ^{cxu.req_cxu, cxu.req_func, cxu.req_data1, 1'b0};

  logic                    r_resp_valid;
  logic [CXU_DATA_W-1:0]   r_resp_data;
  logic [CXU_STATUS_W-1:0] r_resp_status;

  // Data and status only load on a valid request so they hold across idle cycles.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_resp_valid  <= 1'b0;
      r_resp_data   <= '0;
      r_resp_status <= CXU_STATUS_SUCCESS;
    end else begin
      r_resp_valid <= cxu.req_valid;
      if (cxu.req_valid) begin
        r_resp_data   <= w_result;
        r_resp_status <= CXU_STATUS_SUCCESS;
      end
    end
  end

  assign cxu.resp_valid  = r_resp_valid;
  assign cxu.resp_data   = r_resp_data;
  assign cxu.resp_status = r_resp_status;
endmodule

// File: tb/tb_popcount_cxu_pipe.sv
// Directed bench for popcount_cxu_pipe: 32-bit and 64-bit instances side by side.
module tb_popcount_cxu_pipe;
  logic clk;
  logic rst_n;
  int   n_cmp;
  int   n_err;

  popcount_cxu_pipe_if #(.CXU_DATA_W(32)) if32 ();
  popcount_cxu_pipe_if #(.CXU_DATA_W(64)) if64 ();

  popcount_cxu_pipe #(.CXU_DATA_W(32)) dut32 (.clk(clk), .rst_n(rst_n), .cxu(if32));
  popcount_cxu_pipe #(.CXU_DATA_W(64)) dut64 (.clk(clk), .rst_n(rst_n), .cxu(if64));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic req32(input logic [31:0] d0, input logic [31:0] d1);
    if32.req_valid = 1'b1;
    if32.req_data0 = d0;
    if32.req_data1 = d1;
  endtask

  task automatic resp32(input string tag, input logic [63:0] exp_cnt);
    chk({tag, "_vld"}, {63'd0, if32.resp_valid}, 64'd1);
    chk({tag, "_dat"}, {32'd0, if32.resp_data}, exp_cnt);
    chk({tag, "_sts"}, {61'd0, if32.resp_status}, 64'd0);
  endtask

  logic [31:0] a;
  logic [31:0] b;
  logic [31:0] d;
  logic [31:0] last_d;
  logic        gap;
  int          sent;
  int          cyc;

  initial begin
    n_cmp = 0;
    n_err = 0;
    if32.req_valid = 1'b0; if32.req_cxu = '0; if32.req_func = '0;
    if32.req_data0 = '0;   if32.req_data1 = '0;
    if64.req_valid = 1'b0; if64.req_cxu = '0; if64.req_func = '0;
    if64.req_data0 = '0;   if64.req_data1 = '0;
    rst_n = 1'b1;
    #1 rst_n = 1'b0;
    #1;
    chk("rst_vld32", {63'd0, if32.resp_valid}, 64'd0);
    chk("rst_dat32", {32'd0, if32.resp_data}, 64'd0);
    chk("rst_sts32", {61'd0, if32.resp_status}, 64'd0);
    chk("rst_vld64", {63'd0, if64.resp_valid}, 64'd0);
    tick();
    tick();
    #3 rst_n = 1'b1;

    // Basic directed values, back to back.
    req32(32'h0000_0000, 32'h0); tick(); resp32("b_zero", 64'd0);
    req32(32'hFFFF_FFFF, 32'h0); tick(); resp32("b_ones", 64'd32);
    req32(32'h0000_00FF, 32'h0); tick(); resp32("b_ff",   64'd8);
    req32(32'h8000_0001, 32'h0); tick(); resp32("b_ends", 64'd2);
    req32(32'hAAAA_AAAA, 32'h0); tick(); resp32("b_alt",  64'd16);

    // Ignored inputs must not disturb the count.
    req32(32'h0000_000F, 32'hFFFF_FFFF);
    if32.req_func = 1'($urandom);
    if32.req_cxu  = 1'($urandom);
    tick(); resp32("ignored", 64'd4);

    // Dot-product back-end usage: XNOR of the operand pair.
    a = 32'h1234_5678; b = 32'h1234_5678;
    req32(~(a ^ b), 32'h0); tick(); resp32("dot_match", 64'd32);
    a = 32'hFFFF_FFFF; b = 32'h0000_0000;
    req32(~(a ^ b), 32'h0); tick(); resp32("dot_anti", 64'd0);

    // Idle cycle: valid drops, data/status hold.
    if32.req_valid = 1'b0;
    if32.req_data0 = 32'h0000_FFFF;
    tick();
    chk("idle_vld",  {63'd0, if32.resp_valid}, 64'd0);
    chk("idle_hold", {32'd0, if32.resp_data}, 64'd0);

    // Reset mid-stream with a request pending.
    req32(32'h0000_00FF, 32'h0); tick(); resp32("pre_rst", 64'd8);
    req32(32'h0000_0007, 32'h0);
    #2 rst_n = 1'b0;
    #1;
    chk("mrst_vld", {63'd0, if32.resp_valid}, 64'd0);
    chk("mrst_dat", {32'd0, if32.resp_data}, 64'd0);
    chk("mrst_sts", {61'd0, if32.resp_status}, 64'd0);
    tick();
    chk("mrst_drop", {63'd0, if32.resp_valid}, 64'd0);
    #3 rst_n = 1'b1;
    req32(32'h0000_0F0F, 32'h0); tick(); resp32("post_rst", 64'd8);
    last_d = 32'd8;

    // Streaming: 100 random requests with periodic idle gaps.
    sent = 0;
    cyc  = 0;
    while (sent < 100) begin
      gap = ((cyc % 13) == 7) || ((cyc % 29) == 11);
      d   = $urandom;
      if (gap) begin
        if32.req_valid = 1'b0;
        if32.req_data0 = d;
      end else begin
        req32(d, $urandom);
        sent++;
      end
      tick();
      chk("stream_vld", {63'd0, if32.resp_valid}, {63'd0, !gap});
      if (gap) begin
        chk("stream_hold", {32'd0, if32.resp_data}, {32'd0, last_d});
      end else begin
        last_d = 32'($countones(d));
        chk("stream_dat", {32'd0, if32.resp_data}, {32'd0, last_d});
      end
      cyc++;
    end
    if32.req_valid = 1'b0;

    // 64-bit instance.
    if64.req_valid = 1'b1;
    if64.req_data0 = 64'hFFFF_FFFF_FFFF_FFFF; tick();
    chk("w64_vld", {63'd0, if64.resp_valid}, 64'd1);
    chk("w64_ones", if64.resp_data, 64'd64);
    if64.req_data0 = 64'h8000_0000_0000_0000; tick();
    chk("w64_msb", if64.resp_data, 64'd1);
    if64.req_data0 = 64'h0000_0000_FFFF_FFFF; tick();
    chk("w64_low", if64.resp_data, 64'd32);
    chk("w64_sts", {61'd0, if64.resp_status}, 64'd0);
    if64.req_valid = 1'b0;
    tick();
    chk("w64_idle", {63'd0, if64.resp_valid}, 64'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule

// File: doc/popcount_cxu_pipe.md
# popcount_cxu_pipe

Single-cycle-latency population-count custom function unit (CXU) for the composable-extension datapath. It returns the number of set bits in operand `req_data0` as an unsigned `CXU_DATA_W`-bit integer; `req_data1` and the function ID are ignored. It serves as a stand-alone `popcount` instruction and as the counting back-end of the binary-neural-net dot-product unit, which XNORs its two operands and feeds the result here with `req_data1` tied to zero.

## Interface
- `CXU_LI_VERSION`, default per `cxu_pkg`: CXU logic-interface version; carried through, not interpreted.
- `CXU_N_CXUS`, default 1: number of CXUs in the system.
- `CXU_CXU_ID_W`, default 0: width of `req_cxu`; may be 0.
- `CXU_FUNC_ID_W`, default 0: width of `req_func`; may be 0.
- `CXU_DATA_W`, default 32: operand and result width; legal values are 32 and 64. Any other value is an elaboration-time error.

Ports:
- `clk` input 1: clock, rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `req_valid` input 1: request strobe.
- `req_cxu` input `CXU_CXU_ID_W`: CXU ID; ignored.
- `req_func` input `CXU_FUNC_ID_W`: function ID; ignored, since every function is popcount.
- `req_data0` input `CXU_DATA_W`: operand to count.
- `req_data1` input `CXU_DATA_W`: ignored.
- `resp_valid` output 1: response strobe.
- `resp_status` output `CXU_STATUS_W`: response status; always `CXU_STATUS_SUCCESS` (0).
- `resp_data` output `CXU_DATA_W`: popcount result.

## Operation
- Count = number of 1 bits in `req_data0`. Range is 0..32 for a 32-bit operand and 0..64 for a 64-bit operand.
- Result is zero-extended to `CXU_DATA_W`. No overflow is possible.
- Count is computed combinationally with a balanced adder tree:
  - Level 0: 2-bit sums of adjacent bit pairs.
  - Each following level adds adjacent sums and widens by 1 bit, up to a 6-bit (32) or 7-bit (64) final sum.
  - The tree is generated from `CXU_DATA_W`, with no hard-coded 32-bit structure.
- All unused inputs are consumed in a lint-silencing reduction and have no functional effect:
  - `req_cxu`, `req_func`, `req_data1`.
  - The upper unused bits of the result are driven to 0.
- Zero-width `req_cxu` and `req_func` must elaborate cleanly.
- There is no error path: every function ID returns success.
- Stateless apart from the output register. Every request is independent.

## Timing
- Latency is exactly 1 cycle. A request sampled with `req_valid`=1 on edge N produces `resp_valid`=1 with `resp_data` and `resp_status` valid after edge N, for one cycle.
- Throughput is one request per cycle. Back-to-back requests give back-to-back responses in order.
- There is no backpressure and no ready signal. The requester must accept every response.
- When `req_valid`=0 at an edge:
  - `resp_valid` goes to 0 on the next cycle.
  - `resp_data` and `resp_status` hold their previous values. They are don't-care to consumers, but the implementation must hold them.
- Reset values while `rst_n`=0, asserted asynchronously: `resp_valid`=0, `resp_data`=0, `resp_status`=`CXU_STATUS_SUCCESS`.
- Reset deassertion is synchronous to `clk` by the system. The first request is accepted on the first edge with `rst_n`=1.
- Reset mid-operation: a request sampled on the same edge during which reset is asserted is dropped, and no response is produced for it.
- A request presented on the first edge after release is processed normally.

## Test plan
- Reset: assert `rst_n`=0 mid-stream with `req_valid`=1.
  - `resp_valid`, `resp_data` and `resp_status` go to 0 immediately, with no clock needed.
  - After release, the next request responds 1 cycle later.
- Basic values, 32-bit, `req_data1`=0, one request per cycle:
  - `req_data0`=0x00000000 → 0.
  - 0xFFFFFFFF → 32.
  - 0x000000FF → 8.
  - 0x80000001 → 2.
  - 0xAAAAAAAA → 16.
  - `resp_status`=0 for all, each exactly 1 cycle after its request.
- Ignored inputs: `req_data0`=0x0000000F with `req_data1`=0xFFFFFFFF and random `req_func`/`req_cxu` → 4.
- Streaming: 100 back-to-back random operands → results match a reference popcount in order, with `resp_valid` held high throughout. Insert `req_valid`=0 gaps → `resp_valid` drops for exactly those cycles.
- 64-bit instance (`CXU_DATA_W`=64):
  - 0xFFFFFFFFFFFFFFFF → 64.
  - 0x8000000000000000 → 1.
  - 0x00000000FFFFFFFF → 32.
- Dot-product usage: drive `req_data0`=~(0x12345678 ^ 0x12345678)=0xFFFFFFFF → 32; drive `req_data0`=~(0xFFFFFFFF ^ 0x00000000)=0 → 0.
